// File: rtl/jesd_tx_pkg.sv
// Shared types and K-character codes for the JESD204B transmit link controller.
package jesd_tx_pkg;

  typedef enum logic [1:0] {
    StCgs  = 2'd0,
    StIlas = 2'd1,
    StData = 2'd2
  } link_state_e;

  // RD- / RD+ encodings of the control characters used by the link layer
  localparam logic [9:0] K28p5Neg = 10'b0011111010;
  localparam logic [9:0] K28p5Pos = 10'b1100000101;
  localparam logic [9:0] K28p0Neg = 10'b0011110100;
  localparam logic [9:0] K28p0Pos = 10'b1100001011;
  localparam logic [9:0] K28p3Neg = 10'b0011110011;
  localparam logic [9:0] K28p3Pos = 10'b1100001100;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous control bit.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/serializer_ctrl.sv
// JESD204B transmit link controller: CGS/ILAS/DATA sequencing, LMFC tracking and
// running-disparity selection of K characters, one 10-bit character every 10 bit_clk cycles.
module serializer_ctrl
  import jesd_tx_pkg::*;
#(
  parameter int unsigned F            = 2,
  parameter int unsigned K            = 16,
  parameter int unsigned ILAS_MF      = 4,
  parameter int unsigned RESYNC_CHARS = 4
) (
  input  logic       bit_clk,
  input  logic       rst_n,
  input  logic       sync_n,
  input  logic [9:0] tx_data,
  output logic       tx_rdy,
  output logic [9:0] char_data,
  output logic       char_strobe,
  output logic [1:0] link_state,
  output logic       lmfc_edge
);

  localparam int unsigned LmfcW = $clog2(F * K);
  localparam int unsigned MfW   = (ILAS_MF > 1) ? $clog2(ILAS_MF) : 1;
  localparam int unsigned RsW   = (RESYNC_CHARS > 1) ? $clog2(RESYNC_CHARS) : 1;

  localparam logic [LmfcW-1:0] LmfcLast = LmfcW'(F * K - 1);
  localparam logic [MfW-1:0]   MfLast   = MfW'(ILAS_MF - 1);
  localparam logic [RsW-1:0]   RsLast   = RsW'(RESYNC_CHARS - 1);

  logic [3:0]       ph_q;
  logic [LmfcW-1:0] lmfc_q, lmfc_d;
  logic [MfW-1:0]   mf_q, mf_d;
  logic [RsW-1:0]   rs_cnt_q, rs_cnt_d;
  link_state_e      state_q, state_d;
  logic [9:0]       char_q, char_d;
  logic             rd_q, rd_d;
  logic             strobe_q;
  logic             edge_q;
  logic             sync_s;
  logic             boundary;
  logic             take_data;
  logic [3:0]       ones_d;

  sync_2ff u_sync (
    .clk_i  (bit_clk),
    .rst_ni (rst_n),
    .d_i    (sync_n),
    .q_o    (sync_s)
  );

  assign boundary = (ph_q == 4'd9);

  // Decision for the character that follows the current boundary
  always_comb begin
    state_d   = state_q;
    mf_d      = mf_q;
    rs_cnt_d  = rs_cnt_q;
    take_data = 1'b0;
    char_d    = char_q;
    lmfc_d    = (lmfc_q == LmfcLast) ? '0 : lmfc_q + LmfcW'(1);

    unique case (state_q)
      StCgs: begin
        if (sync_s && (lmfc_d == '0)) begin
          state_d = StIlas;
          mf_d    = '0;
        end
      end
      StIlas: begin
        if (!sync_s) begin
          state_d = StCgs;
        end else if (lmfc_q == LmfcLast) begin
          if (mf_q == MfLast) begin
            state_d = StData;
          end else begin
            mf_d = mf_q + MfW'(1);
          end
        end
      end
      StData: begin
        if (sync_s) begin
          rs_cnt_d = '0;
        end else if (rs_cnt_q == RsLast) begin
          state_d  = StCgs;
          rs_cnt_d = '0;
        end else begin
          rs_cnt_d = rs_cnt_q + RsW'(1);
        end
      end
      default: state_d = StCgs;
    endcase

    unique case (state_d)
      StIlas: begin
        if (lmfc_d == '0) begin
          char_d = rd_q ? K28p0Pos : K28p0Neg;
        end else if (lmfc_d == LmfcLast) begin
          char_d = rd_q ? K28p3Pos : K28p3Neg;
        end else begin
          take_data = 1'b1;
        end
      end
      StData:  take_data = 1'b1;
      default: char_d = rd_q ? K28p5Pos : K28p5Neg;
    endcase

    if (take_data) begin
      char_d = tx_data;
    end

    ones_d = '0;
    for (int i = 0; i < 10; i++) begin
      ones_d = ones_d + 4'(char_d[i]);
    end
    // Unbalanced characters (including out-of-table data) always flip disparity
    rd_d = rd_q ^ (ones_d != 4'd5);
  end

  always_ff @(posedge bit_clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q     <= 4'd0;
      lmfc_q   <= '0;
      mf_q     <= '0;
      rs_cnt_q <= '0;
      state_q  <= StCgs;
      char_q   <= K28p5Neg;
      rd_q     <= 1'b1;
      strobe_q <= 1'b0;
      edge_q   <= 1'b0;
    end else begin
      strobe_q <= boundary;
      edge_q   <= boundary && (lmfc_d == '0);
      if (boundary) begin
        ph_q     <= 4'd0;
        lmfc_q   <= lmfc_d;
        mf_q     <= mf_d;
        rs_cnt_q <= rs_cnt_d;
        state_q  <= state_d;
        char_q   <= char_d;
        rd_q     <= rd_d;
      end else begin
        ph_q <= ph_q + 4'd1;
      end
    end
  end

  assign tx_rdy      = boundary && take_data;
  assign char_data   = char_q;
  assign char_strobe = strobe_q;
  assign link_state  = state_q;
  assign lmfc_edge   = edge_q;

endmodule

// File: tb/tb_serializer_ctrl.sv
// Directed bench for serializer_ctrl with default parameters (F=2, K=16, ILAS_MF=4, RESYNC_CHARS=4).
module tb_serializer_ctrl;

  localparam int FK = 32;

  localparam logic [9:0] R5N = 10'b0011111010;
  localparam logic [9:0] R5P = 10'b1100000101;
  localparam logic [9:0] R0N = 10'b0011110100;
  localparam logic [9:0] R0P = 10'b1100001011;
  localparam logic [9:0] R3N = 10'b0011110011;
  localparam logic [9:0] R3P = 10'b1100001100;

  logic       bit_clk = 1'b0;
  logic       rst_n;
  logic       sync_n;
  logic [9:0] tx_data;
  logic       tx_rdy;
  logic [9:0] char_data;
  logic       char_strobe;
  logic [1:0] link_state;
  logic       lmfc_edge;

  int   total = 0;
  int   bad = 0;
  int   pos = 0;
  logic exp_rd = 1'b1;
  int   rdy_total = 0;

  serializer_ctrl dut (
    .bit_clk     (bit_clk),
    .rst_n       (rst_n),
    .sync_n      (sync_n),
    .tx_data     (tx_data),
    .tx_rdy      (tx_rdy),
    .char_data   (char_data),
    .char_strobe (char_strobe),
    .link_state  (link_state),
    .lmfc_edge   (lmfc_edge)
  );

  always #5 bit_clk = ~bit_clk;

  always @(negedge bit_clk) if (tx_rdy === 1'b1) rdy_total++;

  function automatic logic [9:0] kc(input int kind, input logic rd);
    case (kind)
      0:       return rd ? R0P : R0N;
      3:       return rd ? R3P : R3N;
      default: return rd ? R5P : R5N;
    endcase
  endfunction

  function automatic int popcnt(input logic [9:0] v);
    int n = 0;
    for (int i = 0; i < 10; i++) n += int'(v[i]);
    return n;
  endfunction

  // Advance to the negedge where the next character's strobe is visible.
  task automatic next_char(output int cycles);
    cycles = 0;
    do begin
      @(negedge bit_clk);
      cycles++;
    end while (char_strobe !== 1'b1 && cycles < 20);
    if (char_strobe !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL next_char timeout: strobe=%b after %0d cycles, need 1", char_strobe, cycles);
    end
    pos = (pos + 1) % FK;
  endtask

  task automatic test_reset();
    int cyc;
    logic [9:0] e;
    rst_n = 1'b0;
    sync_n = 1'b0;
    tx_data = 10'd0;
    repeat (3) @(negedge bit_clk);
    total++; if (char_data !== R5N) begin bad++; $display("FAIL reset char_data: got %b need %b", char_data, R5N); end
    total++; if (link_state !== 2'd0) begin bad++; $display("FAIL reset link_state: got %0d need 0", link_state); end
    total++; if (tx_rdy !== 1'b0) begin bad++; $display("FAIL reset tx_rdy: got %b need 0", tx_rdy); end
    total++; if (char_strobe !== 1'b0) begin bad++; $display("FAIL reset char_strobe: got %b need 0", char_strobe); end
    total++; if (lmfc_edge !== 1'b0) begin bad++; $display("FAIL reset lmfc_edge: got %b need 0", lmfc_edge); end
    rst_n = 1'b1;
    pos = 0;
    exp_rd = 1'b1;
    next_char(cyc);
    total++; if (cyc !== 10) begin bad++; $display("FAIL first strobe delay: got %0d need 10", cyc); end
    e = kc(5, exp_rd);
    total++; if (char_data !== e) begin bad++; $display("FAIL first cgs char: got %b need %b", char_data, e); end
    exp_rd ^= (popcnt(e) != 5);
  endtask

  task automatic test_cgs();
    int cyc;
    int r0;
    logic [9:0] e;
    r0 = rdy_total;
    for (int i = 0; i < 99; i++) begin
      next_char(cyc);
      e = kc(5, exp_rd);
      total++; if (cyc !== 10) begin bad++; $display("FAIL cgs strobe period: got %0d need 10", cyc); end
      total++; if (char_data !== e) begin bad++; $display("FAIL cgs char %0d: got %b need %b", i, char_data, e); end
      total++; if (link_state !== 2'd0) begin bad++; $display("FAIL cgs state: got %0d need 0", link_state); end
      total++;
      if (lmfc_edge !== (pos == 0)) begin
        bad++; $display("FAIL cgs lmfc_edge pos %0d: got %b need %b", pos, lmfc_edge, pos == 0);
      end
      exp_rd ^= (popcnt(e) != 5);
    end
    total++; if (rdy_total - r0 !== 0) begin bad++; $display("FAIL cgs tx_rdy pulses: got %0d need 0", rdy_total - r0); end
  endtask

  task automatic test_ilas();
    int cyc;
    int r0;
    logic [9:0] e;
    tx_data = 10'b0101010101;
    while (pos != 10) begin
      next_char(cyc);
      e = kc(5, exp_rd);
      total++; if (char_data !== e) begin bad++; $display("FAIL pre-sync cgs char: got %b need %b", char_data, e); end
      exp_rd ^= (popcnt(e) != 5);
    end
    sync_n = 1'b1;
    repeat (FK - 11) begin
      next_char(cyc);
      e = kc(5, exp_rd);
      total++; if (char_data !== e) begin bad++; $display("FAIL wait-lmfc char: got %b need %b", char_data, e); end
      total++; if (link_state !== 2'd0) begin bad++; $display("FAIL wait-lmfc state: got %0d need 0", link_state); end
      exp_rd ^= (popcnt(e) != 5);
    end
    r0 = 0;
    for (int mf = 0; mf < 4; mf++) begin
      for (int p = 0; p < FK; p++) begin
        next_char(cyc);
        if (mf == 0 && p == 0) r0 = rdy_total;
        e = (p == 0) ? kc(0, exp_rd) : (p == FK - 1) ? kc(3, exp_rd) : tx_data;
        total++; if (char_data !== e) begin bad++; $display("FAIL ilas mf%0d pos%0d: got %b need %b", mf, p, char_data, e); end
        total++; if (link_state !== 2'd1) begin bad++; $display("FAIL ilas state mf%0d pos%0d: got %0d need 1", mf, p, link_state); end
        total++;
        if (lmfc_edge !== (p == 0)) begin
          bad++; $display("FAIL ilas lmfc_edge mf%0d pos%0d: got %b need %b", mf, p, lmfc_edge, p == 0);
        end
        exp_rd ^= (popcnt(e) != 5);
      end
    end
    total++; if (rdy_total - r0 !== 120) begin bad++; $display("FAIL ilas tx_rdy pulses: got %0d need 120", rdy_total - r0); end
    next_char(cyc);
    total++; if (link_state !== 2'd2) begin bad++; $display("FAIL data entry state: got %0d need 2", link_state); end
    total++; if (char_data !== tx_data) begin bad++; $display("FAIL data entry char: got %b need %b", char_data, tx_data); end
    exp_rd ^= (popcnt(tx_data) != 5);
  endtask

  task automatic test_resync_short();
    int cyc;
    int r0;
    r0 = rdy_total;
    sync_n = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      next_char(cyc);
      if (i == 3) sync_n = 1'b1;
      total++; if (link_state !== 2'd2) begin bad++; $display("FAIL short-low state char %0d: got %0d need 2", i, link_state); end
      total++; if (char_data !== tx_data) begin bad++; $display("FAIL short-low char %0d: got %b need %b", i, char_data, tx_data); end
      exp_rd ^= (popcnt(tx_data) != 5);
    end
    total++; if (rdy_total - r0 !== 7) begin bad++; $display("FAIL short-low tx_rdy pulses: got %0d need 7", rdy_total - r0); end
  endtask

  task automatic test_disparity_resync();
    int cyc;
    logic [9:0] e;
    tx_data = 10'b1111110000;
    for (int i = 0; i < 6; i++) begin
      next_char(cyc);
      total++; if (char_data !== tx_data) begin bad++; $display("FAIL unbalanced data %0d: got %b need %b", i, char_data, tx_data); end
      exp_rd ^= (popcnt(tx_data) != 5);
    end
    sync_n = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      next_char(cyc);
      total++; if (link_state !== 2'd2) begin bad++; $display("FAIL long-low state char %0d: got %0d need 2", i, link_state); end
      total++; if (char_data !== tx_data) begin bad++; $display("FAIL long-low char %0d: got %b need %b", i, char_data, tx_data); end
      exp_rd ^= (popcnt(tx_data) != 5);
    end
    for (int i = 0; i < 2; i++) begin
      next_char(cyc);
      e = kc(5, exp_rd);
      total++; if (link_state !== 2'd0) begin bad++; $display("FAIL resync state %0d: got %0d need 0", i, link_state); end
      total++; if (char_data !== e) begin bad++; $display("FAIL resync K28.5 rd %0d: got %b need %b", i, char_data, e); end
      exp_rd ^= (popcnt(e) != 5);
    end
  endtask

  task automatic test_reset_mid_ilas();
    int cyc;
    int r0;
    logic [9:0] e;
    tx_data = 10'b0101010101;
    sync_n = 1'b1;
    for (int g = 0; g < FK; g++) begin
      next_char(cyc);
      if (pos == 0) break;
      e = kc(5, exp_rd);
      total++; if (char_data !== e) begin bad++; $display("FAIL rehandshake cgs char: got %b need %b", char_data, e); end
      exp_rd ^= (popcnt(e) != 5);
    end
    e = kc(0, exp_rd);
    total++; if (char_data !== e) begin bad++; $display("FAIL rehandshake /R/: got %b need %b", char_data, e); end
    exp_rd ^= (popcnt(e) != 5);
    for (int k = 1; k <= 2 * FK; k++) begin
      next_char(cyc);
      e = (pos == 0) ? kc(0, exp_rd) : (pos == FK - 1) ? kc(3, exp_rd) : tx_data;
      total++; if (char_data !== e) begin bad++; $display("FAIL pre-reset ilas %0d: got %b need %b", k, char_data, e); end
      total++; if (link_state !== 2'd1) begin bad++; $display("FAIL pre-reset state %0d: got %0d need 1", k, link_state); end
      exp_rd ^= (popcnt(e) != 5);
    end
    // At the /R/ strobe of multiframe 2: assert reset asynchronously
    rst_n = 1'b0;
    sync_n = 1'b0;
    #1;
    total++; if (char_data !== R5N) begin bad++; $display("FAIL mid-ilas reset char: got %b need %b", char_data, R5N); end
    total++; if (link_state !== 2'd0) begin bad++; $display("FAIL mid-ilas reset state: got %0d need 0", link_state); end
    total++; if (char_strobe !== 1'b0) begin bad++; $display("FAIL mid-ilas reset strobe: got %b need 0", char_strobe); end
    total++; if (lmfc_edge !== 1'b0) begin bad++; $display("FAIL mid-ilas reset lmfc_edge: got %b need 0", lmfc_edge); end
    total++; if (tx_rdy !== 1'b0) begin bad++; $display("FAIL mid-ilas reset tx_rdy: got %b need 0", tx_rdy); end
    repeat (2) @(negedge bit_clk);
    rst_n = 1'b1;
    pos = 0;
    exp_rd = 1'b1;
    r0 = rdy_total;
    for (int i = 0; i < 40; i++) begin
      next_char(cyc);
      e = kc(5, exp_rd);
      total++; if (char_data !== e) begin bad++; $display("FAIL post-reset cgs %0d: got %b need %b", i, char_data, e); end
      total++; if (link_state !== 2'd0) begin bad++; $display("FAIL post-reset state %0d: got %0d need 0", i, link_state); end
      exp_rd ^= (popcnt(e) != 5);
    end
    total++; if (rdy_total - r0 !== 0) begin bad++; $display("FAIL post-reset tx_rdy pulses: got %0d need 0", rdy_total - r0); end
    sync_n = 1'b1;
    for (int g = 0; g < FK; g++) begin
      next_char(cyc);
      if (pos == 0) break;
      total++; if (link_state !== 2'd0) begin bad++; $display("FAIL restart wait state: got %0d need 0", link_state); end
      exp_rd ^= (popcnt(kc(5, exp_rd)) != 5);
    end
    e = kc(0, exp_rd);
    total++; if (char_data !== e) begin bad++; $display("FAIL restart /R/: got %b need %b", char_data, e); end
    total++; if (link_state !== 2'd1) begin bad++; $display("FAIL restart state: got %0d need 1", link_state); end
    total++; if (lmfc_edge !== 1'b1) begin bad++; $display("FAIL restart lmfc_edge: got %b need 1", lmfc_edge); end
  endtask

  initial begin
    test_reset();
    test_cgs();
    test_ilas();
    test_resync_short();
    test_disparity_resync();
    test_reset_mid_ilas();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
